rf_read_arbiter: RTL and testbench
==================================

Name: rf_read_arbiter

Overview:
Round-robin arbiter that shares the single 32-entry register-file read port between NREQ requesters, for example the decode stage, a debug reader and a trace unit. It drives the read port's 5-bit address and enable, then captures the 32-bit read data into a registered response. A response is returned to the winning requester two cycles after its request is accepted, and the port sustains one read per cycle.

Parameters:
NREQ, 4, number of requesters (2..8; need not be a power of two)
AW, 5, register address width
DW, 32, data width

Ports:
clk  in  1  clock; all state updates on rising edge
rst_n  in  1  asynchronous active-low reset
req  in  NREQ  per-requester read request (level)
req_addr  in  NREQ*AW  per-requester register address; requester i uses bits [i*AW +: AW]
gnt  out  NREQ  one-hot combinational grant; a read is accepted at any edge where req[i] and gnt[i] are both high
flush  in  1  synchronous cancel of all in-flight reads
sel_addr  out  AW  read-port address (registered)
sel_ena  out  1  read-port enable (registered); the port output floats to Z when this is low
sel_data  in  DW  read-port output data
rsp_valid  out  NREQ  one-hot, one-cycle response strobe
rsp_data  out  DW  captured read data (registered)
busy  out  1  high when sel_ena or any rsp_valid bit is high

Behaviour:
- Reset (rst_n=0, asynchronous):
  - sel_addr=0, sel_ena=0, rsp_valid=0, rsp_data=0.
  - Internal owner index=0, round-robin pointer ptr=0.
  - gnt is forced to 0 while rst_n=0.
  - Any in-flight read is discarded and no response is produced for it.
- Arbitration (combinational):
  - Search req starting at index ptr, ascending and wrapping at NREQ-1 to 0.
  - The first set bit wins and its gnt bit is set; gnt=0 when req=0 or flush=1.
  - gnt must not depend on sel_data or rsp_*.
- Stage 1, at the edge ending an accept cycle T (winner i):
  - sel_addr <= req_addr[i], sel_ena <= 1, owner <= i.
  - ptr <= (i+1) mod NREQ; the modulus is explicit, so there is no power-of-two wrap assumption.
  - With no accept: sel_ena <= 0, sel_addr holds, ptr holds.
- Stage 2, at the edge ending cycle T+1:
  - If sel_ena=1 and flush=0: rsp_data <= sel_data and rsp_valid <= onehot(owner).
  - Otherwise rsp_valid <= 0 and rsp_data holds. Z/X from an idle port is never captured.
- Timing:
  - Latency: req accepted in cycle T gives rsp_valid high during cycle T+2.
  - Throughput: one accept per cycle, so back-to-back grants produce back-to-back responses.
- Request protocol:
  - Each accepting edge is exactly one read.
  - A requester that keeps req high after an accept requests another read.
  - req_addr must be stable while req is high and gnt is low.
- Flush:
  - When flush=1 in cycle C: no accept in C, sel_ena <= 0, and no rsp_valid in C+1 (the stage-2 capture is suppressed).
  - ptr is unchanged.
- Address 0 is forwarded like any other address; register $0 semantics belong to the register file.
- Simultaneous req and flush: flush wins and gnt=0.
- Single requester held high: granted every cycle regardless of ptr.

Test Plan:
1. Reset mid-read: accept requester 1, then assert rst_n=0 in T+1 -> sel_ena=0, rsp_valid=0, rsp_data=0 immediately; ptr=0; no response after release.
2. Single read: port model returns 0x1000_0000+addr; req=0b0010, req_addr[1]=13 in cycle T -> gnt=0b0010 in T; sel_addr=13, sel_ena=1 in T+1; rsp_valid=0b0010, rsp_data=0x1000_000D in T+2.
3. All four requesting continuously from ptr=0 -> gnt sequence 0001, 0010, 0100, 1000, 0001 on consecutive cycles; matching rsp_valid two cycles later with correct data each cycle.
4. Wrap and fairness: ptr=2 with req=0b1001 -> gnt=0b1000, then ptr=0 gives gnt=0b0001, then ptr=1; with NREQ=3, winner 2 sets ptr back to 0.
5. Flush: accept in T, flush=1 in T+1 -> no rsp_valid in T+2, rsp_data keeps its prior value, sel_ena=0 in T+2; req held during flush -> gnt=0 that cycle.
6. Idle port: req=0 for 5 cycles with sel_data driven Z -> sel_ena=0, rsp_valid=0, rsp_data unchanged and never X; busy=0.

Source files
------------

// File: rtl/rf_read_arbiter.sv
// rf_read_arbiter: round-robin sharing of one register-file read port.
// Accept in cycle T -> port address/enable in T+1 -> registered response in T+2.
// One read can be accepted every cycle. flush cancels the read that is on the port.
module rf_read_arbiter #(
    parameter int NREQ = 4,
    parameter int AW   = 5,
    parameter int DW   = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NREQ-1:0]    req,
    input  logic [NREQ*AW-1:0] req_addr,
    output logic [NREQ-1:0]    gnt,
    input  logic               flush,
    output logic [AW-1:0]      sel_addr,
    output logic               sel_ena,
    input  logic [DW-1:0]      sel_data,
    output logic [NREQ-1:0]    rsp_valid,
    output logic [DW-1:0]      rsp_data,
    output logic               busy
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [PW-1:0]   ptr;
    logic [PW-1:0]   owner;
    logic [PW-1:0]   winIdx;
    logic [PW-1:0]   ptrNext;
    logic [PW:0]     candIdx;
    logic            accept;
    logic [NREQ-1:0] ownerOneHot;
    logic [AW-1:0]   winAddr;

    // Round-robin search starting at ptr. Indices wrap by subtracting NREQ,
    // so NREQ does not have to be a power of two.
    always_comb begin
        gnt     = '0;
        winIdx  = '0;
        accept  = 1'b0;
        candIdx = '0;
        for (int k = 0; k < NREQ; k++) begin
            candIdx = {1'b0, ptr} + (PW+1)'(k);
            if (candIdx >= (PW+1)'(NREQ)) begin
                candIdx = candIdx - (PW+1)'(NREQ);
            end
            if (!accept && req[candIdx[PW-1:0]]) begin
                accept                 = 1'b1;
                winIdx                 = candIdx[PW-1:0];
                gnt[candIdx[PW-1:0]]   = 1'b1;
            end
        end
        // A cancelled cycle accepts nothing. Nothing is granted while in reset.
        if (!rst_n || flush) begin
            gnt    = '0;
            accept = 1'b0;
        end
    end

    // Winner's address, the pointer after the winner, and the owner as a one-hot mask.
    always_comb begin
        winAddr = req_addr[winIdx*AW +: AW];
        ptrNext = (winIdx == PW'(NREQ-1)) ? '0 : winIdx + PW'(1);
        ownerOneHot        = '0;
        ownerOneHot[owner] = 1'b1;
    end

    // Stage 1: put the winner's address on the read port and advance the pointer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sel_addr <= '0;
            sel_ena  <= 1'b0;
            owner    <= '0;
            ptr      <= '0;
        end else if (accept) begin
            sel_addr <= winAddr;
            sel_ena  <= 1'b1;
            owner    <= winIdx;
            ptr      <= ptrNext;
        end else begin
            sel_ena  <= 1'b0;
        end
    end

    // Stage 2: capture port data only when a live read is on the port. An idle
    // port floats, so rsp_data keeps its value instead of loading Z/X.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid <= '0;
            rsp_data  <= '0;
        end else if (sel_ena && !flush) begin
            rsp_valid <= ownerOneHot;
            rsp_data  <= sel_data;
        end else begin
            rsp_valid <= '0;
        end
    end

    // Read port or response stage is occupied.
    always_comb begin
        busy = sel_ena | (|rsp_valid);
    end

endmodule

// File: tb/tb_rf_read_arbiter.sv
// Scoreboard bench for rf_read_arbiter. The driver computes each grant from the
// round-robin rule and queues the expected response. The monitor pops an entry
// whenever the DUT raises rsp_valid.
module tb_rf_read_arbiter;

    localparam int NREQ = 4;
    localparam int AW   = 5;
    localparam int DW   = 32;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [NREQ-1:0]   req = '0;
    logic [NREQ*AW-1:0] reqAddr = '0;
    logic [NREQ-1:0]   gnt;
    logic              flush = 1'b0;
    logic [AW-1:0]     selAddr;
    logic              selEna;
    wire  [DW-1:0]     selData;
    logic [NREQ-1:0]   rspValid;
    logic [DW-1:0]     rspData;
    logic              busy;

    rf_read_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .req_addr(reqAddr), .gnt(gnt),
        .flush(flush), .sel_addr(selAddr), .sel_ena(selEna), .sel_data(selData),
        .rsp_valid(rspValid), .rsp_data(rspData), .busy(busy)
    );

    // Register-file read port: returns 0x1000_0000 + address while it is enabled.
    assign selData = selEna ? (32'h1000_0000 + {27'b0, selAddr}) : 'z;

    always #5 clk = ~clk;

    int cycleNum = 0;
    always @(posedge clk) cycleNum <= cycleNum + 1;

    typedef struct {
        logic [NREQ-1:0] mask;
        logic [DW-1:0]   data;
        int              due;
    } expEntry_t;

    expEntry_t sbQ[$];

    int checks = 0;
    int errors = 0;

    int              modelPtr = 0;
    logic            acc1 = 1'b0;
    logic            acc2 = 1'b0;
    logic            flushPrev = 1'b0;
    logic [AW-1:0]   addr1 = '0;
    logic [DW-1:0]   expLastData = '0;
    logic [NREQ-1:0] lastGnt = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cycleNum);
        end
    endtask

    // One cycle: check registered outputs, drive inputs, check the grant, update the model.
    task automatic driveCycle(input logic [NREQ-1:0] r, input logic [NREQ*AW-1:0] a,
                              input logic f);
        int win;
        logic [NREQ-1:0]    expGnt;
        logic [NREQ*AW-1:0] shifted;
        logic               rspNow;
        expEntry_t          e;
        @(negedge clk);
        rspNow = acc2 && !flushPrev;
        check("sel_ena", {31'b0, selEna}, {31'b0, acc1});
        if (acc1) check("sel_addr", {27'b0, selAddr}, {27'b0, addr1});
        check("busy", {31'b0, busy}, {31'b0, acc1 | rspNow});
        req = r;
        reqAddr = a;
        flush = f;
        #1;
        win = -1;
        expGnt = '0;
        if (!f) begin
            for (int k = 0; k < NREQ; k++) begin
                int idx;
                idx = (modelPtr + k) % NREQ;
                if (win < 0 && ((r >> idx) & 4'b1) != 4'b0) win = idx;
            end
        end
        if (win >= 0) expGnt = 4'(1 << win);
        check("gnt", {28'b0, gnt}, {28'b0, expGnt});
        lastGnt = expGnt;
        if (f && sbQ.size() > 0 && sbQ[$].due == cycleNum + 1) void'(sbQ.pop_back());
        acc2 = acc1;
        acc1 = (win >= 0);
        flushPrev = f;
        if (win >= 0) begin
            shifted = a >> (win * AW);
            addr1 = shifted[AW-1:0];
            e.mask = expGnt;
            e.data = 32'h1000_0000 + {27'b0, addr1};
            e.due = cycleNum + 2;
            sbQ.push_back(e);
            modelPtr = (win + 1) % NREQ;
        end
    endtask

    task automatic modelReset();
        sbQ.delete();
        modelPtr = 0;
        acc1 = 1'b0;
        acc2 = 1'b0;
        flushPrev = 1'b0;
        expLastData = '0;
        lastGnt = '0;
    endtask

    // Monitor: every response must match the oldest queued expectation in the cycle it is due.
    initial begin
        expEntry_t e;
        forever begin
            @(posedge clk);
            #2;
            if (rst_n) begin
                if (rspValid != '0) begin
                    if (sbQ.size() == 0) begin
                        check("rsp_unexpected", {28'b0, rspValid}, 32'h0);
                    end else begin
                        e = sbQ.pop_front();
                        check("rsp_cycle", cycleNum, e.due);
                        check("rsp_valid", {28'b0, rspValid}, {28'b0, e.mask});
                        check("rsp_data", rspData, e.data);
                        expLastData = e.data;
                    end
                end else if (sbQ.size() > 0 && sbQ[0].due <= cycleNum) begin
                    e = sbQ.pop_front();
                    check("rsp_missing", {28'b0, rspValid}, {28'b0, e.mask});
                end
                check("rsp_data_hold", rspData, expLastData);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, time %0t expected below 2000000", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [NREQ*AW-1:0] a;
        logic [NREQ-1:0]    r;
        logic [NREQ-1:0]    prevReq;

        // Reset with every requester asserted: outputs cleared and no grant.
        req = 4'b1111;
        #3;
        check("rst_gnt", {28'b0, gnt}, 32'h0);
        check("rst_sel_ena", {31'b0, selEna}, 32'h0);
        check("rst_sel_addr", {27'b0, selAddr}, 32'h0);
        check("rst_rsp_valid", {28'b0, rspValid}, 32'h0);
        check("rst_rsp_data", rspData, 32'h0);
        check("rst_busy", {31'b0, busy}, 32'h0);
        req = '0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Single read: requester 1, address 13.
        a = '0;
        a[1*AW +: AW] = 5'd13;
        driveCycle(4'b0010, a, 1'b0);
        driveCycle(4'b0000, a, 1'b0);
        driveCycle(4'b0000, a, 1'b0);

        // All four requesters continuously: 0001? pointer is 2 now -> rotates through all.
        a = {5'd31, 5'd0, 5'd7, 5'd20};
        for (int i = 0; i < 6; i++) driveCycle(4'b1111, a, 1'b0);

        // Wrap: get ptr to 2, then req=1001 picks 3, then 0.
        driveCycle(4'b0010, a, 1'b0);
        driveCycle(4'b1001, a, 1'b0);
        driveCycle(4'b1001, a, 1'b0);
        driveCycle(4'b0000, a, 1'b0);

        // Flush: accept then flush with request held.
        driveCycle(4'b0100, a, 1'b0);
        driveCycle(4'b0100, a, 1'b1);
        driveCycle(4'b0000, a, 1'b0);
        driveCycle(4'b0000, a, 1'b0);

        // Flush and request in the same cycle with nothing in flight.
        driveCycle(4'b1111, a, 1'b1);

        // Idle port: requests low, the port floats, rsp_data must hold.
        for (int i = 0; i < 5; i++) driveCycle(4'b0000, a, 1'b0);

        // Reset in the cycle after an accept: the read must vanish.
        a[1*AW +: AW] = 5'd9;
        driveCycle(4'b0010, a, 1'b0);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("mid_rst_sel_ena", {31'b0, selEna}, 32'h0);
        check("mid_rst_rsp_valid", {28'b0, rspValid}, 32'h0);
        check("mid_rst_rsp_data", rspData, 32'h0);
        check("mid_rst_gnt", {28'b0, gnt}, 32'h0);
        req = '0;
        modelReset();
        @(negedge clk);
        rst_n = 1'b1;
        // After reset the pointer is 0: all requesting grants requester 0.
        driveCycle(4'b1111, a, 1'b0);
        driveCycle(4'b0000, a, 1'b0);
        driveCycle(4'b0000, a, 1'b0);

        // Random traffic. An address is held while its request waits ungranted.
        prevReq = '0;
        for (int i = 0; i < 400; i++) begin
            r = 4'($urandom);
            for (int j = 0; j < NREQ; j++) begin
                if (!(prevReq[j] && !lastGnt[j])) a[j*AW +: AW] = 5'($urandom);
            end
            driveCycle(r, a, ($urandom_range(0, 7) == 0));
            prevReq = r;
        end

        for (int i = 0; i < 4; i++) driveCycle(4'b0000, a, 1'b0);
        check("sb_drained", sbQ.size(), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
